// File: rtl/axilite_modport_regfile_pkg.sv
// Shared AXI typedefs for the register-file slice.
// Holds the response code enum, the protection-field struct and the helper
// that turns a byte-strobe width into the number of address offset bits.
package hs_bus_amba_axi_typedefs_pkg;

  typedef enum logic [1:0] {
    XRESP_OKAY   = 2'b00,
    XRESP_EXOKAY = 2'b01,
    XRESP_SLVERR = 2'b10,
    XRESP_DECERR = 2'b11
  } xresp_e;

  typedef struct packed {
    logic instr;
    logic nonsec;
    logic priv;
  } axprot_s;

  // Number of low address bits that select a byte inside one data word.
  function automatic int byte_offset_bits(input int strb_width);
    return $clog2(strb_width);
  endfunction

endpackage

// File: rtl/axilite_modport_regfile_if.sv
// AXI5-Lite bus bundle with master and slave views.
// Channels: AW (request), W (data), B (write response), AR (read request),
// R (read response). Each channel has a valid/ready pair plus its payload.
interface axilite_modport_regfile_if
  import hs_bus_amba_axi_typedefs_pkg::*;
#(
  parameter int ID_W_WIDTH      = 1,
  parameter int ID_R_WIDTH      = 1,
  parameter int ADDR_WIDTH      = 32,
  parameter int DATA_WIDTH      = 32,
  parameter int STRB_WIDTH      = DATA_WIDTH / 8,
  parameter int USER_DATA_WIDTH = 1,
  parameter int USER_RESP_WIDTH = 1,
  parameter int SUBSYSID_WIDTH  = 3
) ();

  logic                       awvalid;
  logic                       awready;
  logic [ID_W_WIDTH-1:0]      awid;
  logic [ADDR_WIDTH-1:0]      awaddr;
  logic [2:0]                 awsize;
  axprot_s                    awprot;
  logic                       awtrace;
  logic                       awidunq;
  logic [SUBSYSID_WIDTH-1:0]  awsubsysid;

  logic                       wvalid;
  logic                       wready;
  logic [DATA_WIDTH-1:0]      wdata;
  logic [STRB_WIDTH-1:0]      wstrb;
  logic [STRB_WIDTH-1:0]      wpoison;
  logic [USER_DATA_WIDTH-1:0] wuser;
  logic                       wtrace;

  logic                       bvalid;
  logic                       bready;
  logic [ID_W_WIDTH-1:0]      bid;
  logic                       bidunq;
  logic [1:0]                 bresp;
  logic [USER_RESP_WIDTH-1:0] buser;
  logic                       btrace;

  logic                       arvalid;
  logic                       arready;
  logic [ID_R_WIDTH-1:0]      arid;
  logic [ADDR_WIDTH-1:0]      araddr;
  logic [2:0]                 arsize;
  axprot_s                    arprot;
  logic                       artrace;
  logic                       aridunq;
  logic [SUBSYSID_WIDTH-1:0]  arsubsysid;
  logic [USER_DATA_WIDTH-1:0] aruser;

  logic                       rvalid;
  logic                       rready;
  logic [ID_R_WIDTH-1:0]      rid;
  logic                       ridunq;
  logic [DATA_WIDTH-1:0]      rdata;
  logic [1:0]                 rresp;
  logic [USER_RESP_WIDTH-1:0] ruser;
  logic [STRB_WIDTH-1:0]      rpoison;
  logic                       rtrace;

  modport master (
    output awvalid, awid, awaddr, awsize, awprot, awtrace, awidunq, awsubsysid,
    input  awready,
    output wvalid, wdata, wstrb, wpoison, wuser, wtrace,
    input  wready,
    input  bvalid, bid, bidunq, bresp, buser, btrace,
    output bready,
    output arvalid, arid, araddr, arsize, arprot, artrace, aridunq, arsubsysid, aruser,
    input  arready,
    input  rvalid, rid, ridunq, rdata, rresp, ruser, rpoison, rtrace,
    output rready
  );

  modport slave (
    input  awvalid, awid, awaddr, awsize, awprot, awtrace, awidunq, awsubsysid,
    output awready,
    input  wvalid, wdata, wstrb, wpoison, wuser, wtrace,
    output wready,
    output bvalid, bid, bidunq, bresp, buser, btrace,
    input  bready,
    input  arvalid, arid, araddr, arsize, arprot, artrace, aridunq, arsubsysid, aruser,
    output arready,
    output rvalid, rid, ridunq, rdata, rresp, ruser, rpoison, rtrace,
    input  rready
  );

endinterface

// File: rtl/axilite_modport_regfile_hold_buf.sv
// One-entry valid/ready holding buffer.
// Ports: aclk/areset; in_valid/in_ready/in_data accept one beat; full/data
// expose the held beat; clear empties the buffer once the beat is consumed.
// Not ready during reset so nothing is accepted while areset is high.
module axilite_hold_buf #(
  parameter int WIDTH = 1
) (
  input  logic             aclk,
  input  logic             areset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             clear,
  output logic             full,
  output logic [WIDTH-1:0] data
);

  assign in_ready = !full && !areset;

  // Capture a beat when empty; a consumer clear can never coincide with a
  // capture because in_ready is low whenever the buffer is full.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      full <= 1'b0;
      data <= '0;
    end else if (clear) begin
      full <= 1'b0;
    end else if (in_valid && in_ready) begin
      full <= 1'b1;
      data <= in_data;
    end
  end

endmodule

// File: rtl/axilite_modport_regfile.sv
// AXI5-Lite subordinate terminating into NUM_REGS registers of DATA_WIDTH.
// Ports: aclk, areset (async, active-high), s = slave view of the bus.
// Writes: AW and W are each parked in a one-entry buffer and committed together
// once the B channel is free. Reads: single-cycle latency from AR to R.
module axilite_modport_regfile
  import hs_bus_amba_axi_typedefs_pkg::*;
#(
  parameter int ID_W_WIDTH      = 1,
  parameter int ID_R_WIDTH      = 1,
  parameter int ADDR_WIDTH      = 32,
  parameter int DATA_WIDTH      = 32,
  parameter int STRB_WIDTH      = DATA_WIDTH / 8,
  parameter int USER_DATA_WIDTH = 1,
  parameter int USER_RESP_WIDTH = 1,
  parameter int SUBSYSID_WIDTH  = 3,
  parameter int NUM_REGS        = 16
) (
  input  logic                        aclk,
  input  logic                        areset,
  axilite_modport_regfile_if.slave    s
);

  localparam int OFFS  = byte_offset_bits(STRB_WIDTH);
  localparam int IDX_W = $clog2(NUM_REGS);

  typedef struct packed {
    logic [ID_W_WIDTH-1:0] id;
    logic [ADDR_WIDTH-1:0] addr;
    logic [2:0]            size;
    logic                  idunq;
    logic                  trace;
  } aw_s;

  typedef struct packed {
    logic [DATA_WIDTH-1:0] data;
    logic [STRB_WIDTH-1:0] strb;
    logic [STRB_WIDTH-1:0] poison;
  } w_s;

  // Address errors take priority over an oversized access.
  function automatic xresp_e decode(input logic [ADDR_WIDTH-1:0] addr,
                                    input logic [2:0]            size);
    logic [ADDR_WIDTH-1:0] idx;
    idx = addr >> OFFS;
    if (idx >= ADDR_WIDTH'(NUM_REGS)) return XRESP_DECERR;
    if (size > 3'(OFFS))              return XRESP_SLVERR;
    return XRESP_OKAY;
  endfunction

  logic [DATA_WIDTH-1:0] regs [NUM_REGS];

  aw_s  aw_in, aw_q;
  w_s   w_in, w_q;
  logic aw_full, w_full, commit;

  xresp_e           wr_resp;
  logic             wr_en;
  logic [IDX_W-1:0] wr_idx;

  xresp_e                rd_resp;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  ar_hs;

  logic                       bvalid_q, bidunq_q, btrace_q;
  logic [ID_W_WIDTH-1:0]      bid_q;
  logic [1:0]                 bresp_q;
  logic                       rvalid_q, ridunq_q, rtrace_q;
  logic [ID_R_WIDTH-1:0]      rid_q;
  logic [1:0]                 rresp_q;
  logic [DATA_WIDTH-1:0]      rdata_q;

  logic unused_inputs;

  assign aw_in = '{id: s.awid, addr: s.awaddr, size: s.awsize,
                   idunq: s.awidunq, trace: s.awtrace};
  assign w_in  = '{data: s.wdata, strb: s.wstrb, poison: s.wpoison};

  // The B slot is free either when empty or when being drained this edge.
  assign commit = aw_full && w_full && (!bvalid_q || s.bready);

  axilite_hold_buf #(.WIDTH($bits(aw_s))) u_aw_buf (
    .aclk     (aclk),
    .areset   (areset),
    .in_valid (s.awvalid),
    .in_ready (s.awready),
    .in_data  (aw_in),
    .clear    (commit),
    .full     (aw_full),
    .data     (aw_q)
  );

  axilite_hold_buf #(.WIDTH($bits(w_s))) u_w_buf (
    .aclk     (aclk),
    .areset   (areset),
    .in_valid (s.wvalid),
    .in_ready (s.wready),
    .in_data  (w_in),
    .clear    (commit),
    .full     (w_full),
    .data     (w_q)
  );

  // Write response: a poisoned byte on any enabled lane drops the whole write.
  always_comb begin
    wr_resp = decode(aw_q.addr, aw_q.size);
    if (wr_resp == XRESP_OKAY && |(w_q.strb & w_q.poison)) begin
      wr_resp = XRESP_SLVERR;
    end
    wr_en  = commit && (wr_resp == XRESP_OKAY);
    wr_idx = aw_q.addr[OFFS +: IDX_W];
  end

  // Register bank with per-byte write enables.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else if (wr_en) begin
      for (int b = 0; b < STRB_WIDTH; b++) begin
        if (w_q.strb[b]) regs[wr_idx][8*b +: 8] <= w_q.data[8*b +: 8];
      end
    end
  end

  // B channel: load on commit, otherwise drop valid once accepted.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      bvalid_q <= 1'b0;
      bid_q    <= '0;
      bidunq_q <= 1'b0;
      btrace_q <= 1'b0;
      bresp_q  <= '0;
    end else if (commit) begin
      bvalid_q <= 1'b1;
      bid_q    <= aw_q.id;
      bidunq_q <= aw_q.idunq;
      btrace_q <= aw_q.trace;
      bresp_q  <= wr_resp;
    end else if (bvalid_q && s.bready) begin
      bvalid_q <= 1'b0;
    end
  end

  assign s.bvalid = bvalid_q;
  assign s.bid    = bid_q;
  assign s.bidunq = bidunq_q;
  assign s.btrace = btrace_q;
  assign s.bresp  = bresp_q;
  assign s.buser  = '0;

  // Read lookup; errored reads return zero data. Reading before the write
  // edge lands gives the old value on a same-edge collision.
  assign s.arready = !rvalid_q && !areset;
  assign ar_hs     = s.arvalid && s.arready;

  always_comb begin
    rd_resp = decode(s.araddr, s.arsize);
    rd_data = '0;
    if (rd_resp == XRESP_OKAY) rd_data = regs[s.araddr[OFFS +: IDX_W]];
  end

  // R channel: one-deep response register.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      rvalid_q <= 1'b0;
      rid_q    <= '0;
      ridunq_q <= 1'b0;
      rtrace_q <= 1'b0;
      rresp_q  <= '0;
      rdata_q  <= '0;
    end else if (ar_hs) begin
      rvalid_q <= 1'b1;
      rid_q    <= s.arid;
      ridunq_q <= s.aridunq;
      rtrace_q <= s.artrace;
      rresp_q  <= rd_resp;
      rdata_q  <= rd_data;
    end else if (rvalid_q && s.rready) begin
      rvalid_q <= 1'b0;
    end
  end

  assign s.rvalid  = rvalid_q;
  assign s.rid     = rid_q;
  assign s.ridunq  = ridunq_q;
  assign s.rtrace  = rtrace_q;
  assign s.rresp   = rresp_q;
  assign s.rdata   = rdata_q;
  assign s.ruser   = '0;
  assign s.rpoison = '0;

  assign unused_inputs = ^{s.awprot, s.awsubsysid, s.wuser, s.wtrace,
                           s.arprot, s.arsubsysid, s.aruser,
                           aw_q.addr, s.araddr};

endmodule

// File: tb/tb_axilite_modport_regfile.sv
// Directed bench for axilite_modport_regfile with a register-array model.
module tb_axilite_modport_regfile;
  import hs_bus_amba_axi_typedefs_pkg::*;

  typedef struct {
    logic       id;
    logic       idunq;
    logic       trace;
    logic [1:0] resp;
  } expB_t;

  typedef struct {
    logic        id;
    logic        idunq;
    logic        trace;
    logic [1:0]  resp;
    logic [31:0] data;
  } expR_t;

  logic aclk;
  logic areset;

  axilite_modport_regfile_if bus ();

  axilite_modport_regfile dut (
    .aclk   (aclk),
    .areset (areset),
    .s      (bus)
  );

  int testsRun    = 0;
  int testsFailed = 0;

  logic [31:0] modelRegs [16];
  expB_t       expB [$];
  expR_t       expR [$];
  logic [31:0] lastRdata;
  logic [1:0]  lastBresp;

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [63:0] act,
                             input logic [63:0] exp);
    testsRun++;
    if (act !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [1:0] modelResp(input logic [31:0] addr,
                                           input logic [2:0] size,
                                           input logic [3:0] strb,
                                           input logic [3:0] poison);
    if ((addr / 4) >= 16)      return 2'd3;
    if (size > 3'd2)           return 2'd2;
    if ((strb & poison) != 0)  return 2'd2;
    return 2'd0;
  endfunction

  // Response checker: every cycle a response is presented it must equal the
  // oldest outstanding expectation; it is retired when the handshake occurs.
  always @(negedge aclk) begin
    if (!areset) begin
      if (bus.bvalid) begin
        if (expB.size() == 0) begin
          checkOutput("b_spurious", {63'd0, bus.bvalid}, 64'd0);
        end else begin
          checkOutput("bid",    {63'd0, bus.bid},    {63'd0, expB[0].id});
          checkOutput("bidunq", {63'd0, bus.bidunq}, {63'd0, expB[0].idunq});
          checkOutput("btrace", {63'd0, bus.btrace}, {63'd0, expB[0].trace});
          checkOutput("bresp",  {62'd0, bus.bresp},  {62'd0, expB[0].resp});
          checkOutput("buser",  {63'd0, bus.buser},  64'd0);
          if (bus.bready) begin
            lastBresp = bus.bresp;
            void'(expB.pop_front());
          end
        end
      end
      if (bus.rvalid) begin
        if (expR.size() == 0) begin
          checkOutput("r_spurious", {63'd0, bus.rvalid}, 64'd0);
        end else begin
          checkOutput("rid",     {63'd0, bus.rid},     {63'd0, expR[0].id});
          checkOutput("ridunq",  {63'd0, bus.ridunq},  {63'd0, expR[0].idunq});
          checkOutput("rtrace",  {63'd0, bus.rtrace},  {63'd0, expR[0].trace});
          checkOutput("rresp",   {62'd0, bus.rresp},   {62'd0, expR[0].resp});
          checkOutput("rdata",   {32'd0, bus.rdata},   {32'd0, expR[0].data});
          checkOutput("rpoison", {60'd0, bus.rpoison}, 64'd0);
          checkOutput("ruser",   {63'd0, bus.ruser},   64'd0);
          if (bus.rready) begin
            lastRdata = bus.rdata;
            void'(expR.pop_front());
          end
        end
      end
    end
  end

  task automatic sendAw(input logic id, input logic [31:0] addr, input logic [2:0] size);
    int  n = 0;
    logic rdy;
    bus.awvalid = 1'b1; bus.awid = id; bus.awaddr = addr; bus.awsize = size;
    bus.awidunq = addr[2]; bus.awtrace = ~id;
    do begin
      @(negedge aclk); rdy = bus.awready;
      @(posedge aclk); #1; n++;
    end while (!rdy && n < 50);
    checkOutput("aw_handshake", {63'd0, rdy}, 64'd1);
    bus.awvalid = 1'b0;
  endtask

  task automatic sendW(input logic [31:0] data, input logic [3:0] strb, input logic [3:0] poison);
    int  n = 0;
    logic rdy;
    bus.wvalid = 1'b1; bus.wdata = data; bus.wstrb = strb; bus.wpoison = poison;
    do begin
      @(negedge aclk); rdy = bus.wready;
      @(posedge aclk); #1; n++;
    end while (!rdy && n < 50);
    checkOutput("w_handshake", {63'd0, rdy}, 64'd1);
    bus.wvalid = 1'b0;
  endtask

  // Full write: records the expected response and updates the model, then
  // drives AW and W either together or with W leading by wLead cycles.
  task automatic applyStimulus(input logic id, input logic [31:0] addr, input logic [2:0] size,
                               input logic [31:0] data, input logic [3:0] strb,
                               input logic [3:0] poison, input int wLead);
    expB_t e;
    e.id = id; e.idunq = addr[2]; e.trace = ~id;
    e.resp = modelResp(addr, size, strb, poison);
    expB.push_back(e);
    if (e.resp == 2'd0) begin
      for (int b = 0; b < 4; b++)
        if (strb[b]) modelRegs[addr / 4][8*b +: 8] = data[8*b +: 8];
    end
    if (wLead == 0) begin
      fork
        sendAw(id, addr, size);
        sendW(data, strb, poison);
      join
    end else begin
      sendW(data, strb, poison);
      for (int c = 0; c < wLead; c++) begin
        @(negedge aclk);
        checkOutput("wready_held_low", {63'd0, bus.wready}, 64'd0);
        checkOutput("no_early_bvalid", {63'd0, bus.bvalid}, 64'd0);
        @(posedge aclk); #1;
      end
      sendAw(id, addr, size);
    end
  endtask

  task automatic applyRead(input logic id, input logic [31:0] addr, input logic [2:0] size);
    expR_t e;
    int    n = 0;
    logic  rdy;
    e.id = id; e.idunq = addr[3]; e.trace = id;
    e.resp = modelResp(addr, size, 4'h0, 4'h0);
    e.data = (e.resp == 2'd0) ? modelRegs[addr / 4] : 32'd0;
    expR.push_back(e);
    bus.arvalid = 1'b1; bus.arid = id; bus.araddr = addr; bus.arsize = size;
    bus.aridunq = addr[3]; bus.artrace = id;
    do begin
      @(negedge aclk); rdy = bus.arready;
      @(posedge aclk); #1; n++;
    end while (!rdy && n < 50);
    checkOutput("ar_handshake", {63'd0, rdy}, 64'd1);
    bus.arvalid = 1'b0;
    checkOutput("r_latency", {63'd0, bus.rvalid}, 64'd1);
  endtask

  task automatic waitDrained();
    int n = 0;
    while ((expB.size() != 0 || expR.size() != 0) && n < 50) begin
      @(posedge aclk); #1; n++;
    end
    checkOutput("drain_timeout", {32'd0, expB.size() + expR.size()}, 64'd0);
  endtask

  task automatic waitBvalid();
    int n = 0;
    while (!bus.bvalid && n < 50) begin
      @(posedge aclk); #1; n++;
    end
    checkOutput("bvalid_timeout", {63'd0, bus.bvalid}, 64'd1);
  endtask

  task automatic checkReset();
    checkOutput("rst_bvalid",  {63'd0, bus.bvalid},  64'd0);
    checkOutput("rst_rvalid",  {63'd0, bus.rvalid},  64'd0);
    checkOutput("rst_awready", {63'd0, bus.awready}, 64'd0);
    checkOutput("rst_wready",  {63'd0, bus.wready},  64'd0);
    checkOutput("rst_arready", {63'd0, bus.arready}, 64'd0);
    checkOutput("rst_bid",     {62'd0, bus.bresp, bus.bid}, 64'd0);
    checkOutput("rst_rdata",   {32'd0, bus.rdata},   64'd0);
  endtask

  initial begin
    areset = 1'b1;
    bus.awvalid = 0; bus.awid = 0; bus.awaddr = 0; bus.awsize = 3'd2; bus.awprot = '0;
    bus.awtrace = 0; bus.awidunq = 0; bus.awsubsysid = 0;
    bus.wvalid = 0; bus.wdata = 0; bus.wstrb = 0; bus.wpoison = 0; bus.wuser = 0; bus.wtrace = 0;
    bus.bready = 1;
    bus.arvalid = 0; bus.arid = 0; bus.araddr = 0; bus.arsize = 3'd2; bus.arprot = '0;
    bus.artrace = 0; bus.aridunq = 0; bus.arsubsysid = 0; bus.aruser = 0;
    bus.rready = 1;
    for (int i = 0; i < 16; i++) modelRegs[i] = 32'd0;
    lastRdata = 32'hFFFF_FFFF;
    lastBresp = 2'd0;

    repeat (2) @(posedge aclk);
    #1;
    checkReset();
    areset = 1'b0;
    @(posedge aclk); #1;

    // Simultaneous AW/W: response appears after the second edge.
    applyStimulus(1'b1, 32'h8, 3'd2, 32'hDEADBEEF, 4'hF, 4'h0, 0);
    @(negedge aclk);
    checkOutput("b_latency_edge_n", {63'd0, bus.bvalid}, 64'd0);
    @(posedge aclk); #1;
    checkOutput("b_latency_edge_n1", {63'd0, bus.bvalid}, 64'd1);
    waitDrained();
    checkOutput("lit_bresp_okay", {62'd0, lastBresp}, 64'd0);
    applyRead(1'b0, 32'h8, 3'd2);
    waitDrained();
    checkOutput("lit_rdata_deadbeef", {32'd0, lastRdata}, 64'hDEADBEEF);

    // W three cycles ahead of AW.
    applyStimulus(1'b0, 32'hC, 3'd2, 32'hCAFEF00D, 4'hF, 4'h0, 3);
    waitDrained();
    applyRead(1'b1, 32'hC, 3'd2);
    waitDrained();
    checkOutput("lit_rdata_cafef00d", {32'd0, lastRdata}, 64'hCAFEF00D);

    // Partial strobes, then a poisoned write that must be dropped.
    applyStimulus(1'b1, 32'h10, 3'd2, 32'h11223344, 4'h5, 4'h0, 0);
    waitDrained();
    applyRead(1'b0, 32'h10, 3'd2);
    waitDrained();
    checkOutput("lit_rdata_strb5", {32'd0, lastRdata}, 64'h00220044);
    applyStimulus(1'b0, 32'h10, 3'd2, 32'h55667788, 4'hF, 4'h1, 0);
    waitDrained();
    checkOutput("lit_bresp_poison", {62'd0, lastBresp}, 64'd2);
    applyRead(1'b1, 32'h10, 3'd2);
    waitDrained();
    checkOutput("lit_rdata_unchanged", {32'd0, lastRdata}, 64'h00220044);
    applyStimulus(1'b1, 32'h14, 3'd2, 32'h12345678, 4'h0, 4'h0, 0);
    waitDrained();

    // Out-of-range index and oversized accesses.
    applyStimulus(1'b1, 32'h40, 3'd2, 32'hFFFFFFFF, 4'hF, 4'h0, 0);
    waitDrained();
    checkOutput("lit_bresp_decerr", {62'd0, lastBresp}, 64'd3);
    applyRead(1'b0, 32'h40, 3'd2);
    waitDrained();
    checkOutput("lit_rdata_decerr", {32'd0, lastRdata}, 64'd0);
    applyStimulus(1'b0, 32'h4, 3'd3, 32'h0BADF00D, 4'hF, 4'h0, 0);
    waitDrained();
    checkOutput("lit_bresp_size", {62'd0, lastBresp}, 64'd2);
    applyRead(1'b1, 32'h4, 3'd3);
    applyRead(1'b0, 32'h4, 3'd2);
    waitDrained();

    // Back-pressure on B: the second write parks in the buffers.
    bus.bready = 1'b0;
    applyStimulus(1'b0, 32'h0, 3'd2, 32'hA5A5A5A5, 4'hF, 4'h0, 0);
    waitBvalid();
    applyStimulus(1'b1, 32'h4, 3'd2, 32'h5A5A5A5A, 4'hF, 4'h0, 0);
    for (int c = 0; c < 5; c++) begin
      @(negedge aclk);
      checkOutput("stall_awready", {63'd0, bus.awready}, 64'd0);
      checkOutput("stall_wready",  {63'd0, bus.wready},  64'd0);
      checkOutput("stall_bvalid",  {63'd0, bus.bvalid},  64'd1);
      @(posedge aclk); #1;
    end
    bus.bready = 1'b1;
    waitDrained();
    applyRead(1'b0, 32'h0, 3'd2);
    applyRead(1'b1, 32'h4, 3'd2);
    waitDrained();
    checkOutput("lit_rdata_stall2", {32'd0, lastRdata}, 64'h5A5A5A5A);

    // Reset while a response is pending.
    bus.bready = 1'b0;
    applyStimulus(1'b1, 32'h8, 3'd2, 32'h77777777, 4'hF, 4'h0, 0);
    waitBvalid();
    #2 areset = 1'b1;
    #1;
    checkReset();
    expB.delete();
    expR.delete();
    for (int i = 0; i < 16; i++) modelRegs[i] = 32'd0;
    @(posedge aclk); #1;
    areset = 1'b0;
    bus.bready = 1'b1;
    @(posedge aclk); #1;
    applyRead(1'b0, 32'h8, 3'd2);
    waitDrained();
    checkOutput("lit_rdata_after_reset", {32'd0, lastRdata}, 64'd0);

    repeat (3) @(posedge aclk);
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
